// File: rtl/sopc_bus_ram_if.sv
// Bus bundle between N core masters and the shared on-chip RAM.
// Master i owns slice i of every vector (bit i, or bits [i*W +: W]).
//   req    : request, held until ready
//   we     : write enable
//   addr   : byte address
//   wdata  : write data
//   mask   : byte enables for writes, bit k gates byte k
//   rdata  : registered read data, held until that master's next completion
//   ready  : one-cycle completion pulse
//   err    : address out of range, valid with ready
interface sopc_bus_ram_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MASK_WIDTH  = DATA_WIDTH / 8
);
  logic [NUM_MASTERS-1:0]            req;
  logic [NUM_MASTERS-1:0]            we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata;
  logic [NUM_MASTERS*MASK_WIDTH-1:0] mask;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] rdata;
  logic [NUM_MASTERS-1:0]            ready;
  logic [NUM_MASTERS-1:0]            err;

  modport master (
    output req, we, addr, wdata, mask,
    input  rdata, ready, err
  );

  modport slave (
    input  req, we, addr, wdata, mask,
    output rdata, ready, err
  );
endinterface

// File: rtl/sopc_bus_ram.sv
// Round-robin multi-master front end onto a single byte-maskable on-chip RAM.
// One transaction in flight; access takes LATENCY cycles after the grant,
// followed by a single response cycle carrying ready (and err).
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of sopc_bus_ram_if (per-master req/we/addr/wdata/mask in,
//         rdata/ready/err out)
module sopc_bus_ram #(
  parameter int unsigned           NUM_MASTERS = 2,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MASK_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned           DEPTH_WORDS = 131072,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned           LATENCY     = 1
) (
  input logic            clk,
  input logic            rst,
  sopc_bus_ram_if.slave  bus
);

  localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned OB = $clog2(MASK_WIDTH);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'(MASK_WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                          state_q;
  logic [GW-1:0]                   grant_q;
  logic [GW-1:0]                   last_grant_q;
  logic [CW-1:0]                   cnt_q;
  logic                            we_q;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [DATA_WIDTH-1:0]           wdata_q;
  logic [MASK_WIDTH-1:0]           mask_q;
  logic [NUM_MASTERS-1:0]          ready_q;
  logic [NUM_MASTERS-1:0]          err_q;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [GW-1:0]         grant_idx;
  logic [GW-1:0]         cand;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IW-1:0]         word_idx;
  logic                  access;

  // Walk candidates from farthest to nearest so the nearest requester after
  // last_grant is the one left standing.
  always_comb begin
    grant_idx = last_grant_q;
    cand      = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = GW'((32'(last_grant_q) + 32'(k)) % NUM_MASTERS);
      if (bus.req[cand]) grant_idx = cand;
    end
  end

  // Offset wraps below BASE_ADDR, so the lower bound is checked separately.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && (64'(offset) < SPAN);
    word_idx = IW'(offset >> OB);
    access   = (state_q == StBusy) && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_MASTERS - 1);
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      ready_q      <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (|bus.req) begin
            grant_q      <= grant_idx;
            last_grant_q <= grant_idx;
            we_q         <= bus.we[grant_idx];
            addr_q       <= bus.addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q      <= bus.wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            mask_q       <= bus.mask[grant_idx*MASK_WIDTH +: MASK_WIDTH];
            cnt_q        <= CW'(LATENCY - 1);
            state_q      <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            ready_q[grant_q] <= 1'b1;
            err_q[grant_q]   <= ~in_range;
            // Writes and faulted accesses return zero.
            if (!we_q && in_range) begin
              rdata_q[grant_q*DATA_WIDTH +: DATA_WIDTH] <= mem[word_idx];
            end else begin
              rdata_q[grant_q*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end
            state_q <= StResp;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM array has no reset; rst gating aborts a write landing on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && access && we_q && in_range) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (mask_q[b]) mem[word_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sopc_bus_ram.sv
// Directed bench for sopc_bus_ram: a LATENCY=1 instance (full depth) and a
// LATENCY=4 instance (small depth) sharing one clock, each with its own reset.
module tb_sopc_bus_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v [2];
  logic [1:0]  req_v   [2];
  logic [1:0]  we_v    [2];
  logic [63:0] addr_v  [2];
  logic [63:0] wdata_v [2];
  logic [7:0]  mask_v  [2];
  logic [63:0] rdata_v [2];
  logic [1:0]  rdy_v   [2];
  logic [1:0]  err_v   [2];

  int n_assert = 0;
  int n_fail   = 0;

  sopc_bus_ram_if #(.NUM_MASTERS(2)) b1 ();
  sopc_bus_ram_if #(.NUM_MASTERS(2)) b4 ();

  assign b1.req = req_v[0];
  assign b1.we = we_v[0];
  assign b1.addr = addr_v[0];
  assign b1.wdata = wdata_v[0];
  assign b1.mask = mask_v[0];
  assign rdata_v[0] = b1.rdata;
  assign rdy_v[0] = b1.ready;
  assign err_v[0] = b1.err;

  assign b4.req = req_v[1];
  assign b4.we = we_v[1];
  assign b4.addr = addr_v[1];
  assign b4.wdata = wdata_v[1];
  assign b4.mask = mask_v[1];
  assign rdata_v[1] = b4.rdata;
  assign rdy_v[1] = b4.ready;
  assign err_v[1] = b4.err;

  sopc_bus_ram #(
    .NUM_MASTERS(2),
    .LATENCY    (1)
  ) dut1 (
    .clk(clk),
    .rst(rst_v[0]),
    .bus(b1)
  );

  sopc_bus_ram #(
    .NUM_MASTERS(2),
    .DEPTH_WORDS(1024),
    .LATENCY    (4)
  ) dut4 (
    .clk(clk),
    .rst(rst_v[1]),
    .bus(b4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction from master m on instance d; returns data, err, ready
  // vector at the pulse and the number of edges from the first req edge.
  task automatic xact(input int d, input int m, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] mk,
                      output logic [31:0] rd, output logic er, output logic [1:0] rv,
                      output int cyc);
    @(negedge clk);
    addr_v[d][m*32 +: 32]  = a;
    wdata_v[d][m*32 +: 32] = wd;
    mask_v[d][m*4 +: 4]    = mk;
    we_v[d][m]             = we;
    req_v[d][m]            = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!rdy_v[d][m] && cyc < 40);
    rd = rdata_v[d][m*32 +: 32];
    er = err_v[d][m];
    rv = rdy_v[d];
    @(negedge clk);
    req_v[d][m] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [1:0]  rv;
  int          cyc;

  initial begin
    int seen;
    int last_t;
    int t;
    int order [4];
    int bad;

    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; req_v[d] = '0; we_v[d] = '0; addr_v[d] = '0;
      wdata_v[d] = '0; mask_v[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    #1;
    chk("rst1_ready", 64'(rdy_v[0]), 64'd0);
    chk("rst1_err", 64'(err_v[0]), 64'd0);
    chk("rst1_rdata", rdata_v[0], 64'd0);
    chk("rst4_rdata", rdata_v[1], 64'd0);

    // Write then read, master 1.
    xact(0, 1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, rv, cyc);
    chk("wr_cyc", 64'(cyc), 64'd2);
    chk("wr_onehot", 64'(rv), 64'b10);
    chk("wr_err", 64'(er), 64'd0);
    chk("wr_rdata", 64'(rd), 64'd0);
    xact(0, 1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, rv, cyc);
    chk("rd_cyc", 64'(cyc), 64'd2);
    chk("rd_data", 64'(rd), 64'hDEAD_BEEF);

    // Byte mask, master 0; mask=0 write must leave the word alone.
    xact(0, 0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, rv, cyc);
    xact(0, 0, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, rd, er, rv, cyc);
    xact(0, 0, 1'b1, 32'h8000_0010, 32'h0000_0000, 4'h0, rd, er, rv, cyc);
    xact(0, 1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, rv, cyc);
    chk("mask0_data", 64'(rd), 64'hDEAD_BEEF);
    xact(0, 0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, rv, cyc);
    chk("mask5_data", 64'(rd), 64'h11BB_33DD);
    chk("hold_m1", 64'(rdata_v[0][63:32]), 64'hDEAD_BEEF);

    // Out of range.
    xact(0, 0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, rv, cyc);
    chk("oor_rd_err", 64'(er), 64'd1);
    chk("oor_rd_data", 64'(rd), 64'd0);
    chk("oor_rd_onehot", 64'(rv), 64'b01);
    xact(0, 0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, rd, er, rv, cyc);
    chk("w0_err", 64'(er), 64'd0);
    xact(0, 1, 1'b1, 32'h8008_0000, 32'h1234_5678, 4'hF, rd, er, rv, cyc);
    chk("oor_wr_err", 64'(er), 64'd1);
    chk("oor_wr_errvec", 64'(err_v[0]), 64'b10);
    xact(0, 1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, rv, cyc);
    chk("oor_word0", 64'(rd), 64'hCAFE_F00D);
    chk("oor_word0_err", 64'(er), 64'd0);

    // Arbitration: both hold req; last grant was master 1.
    @(negedge clk);
    addr_v[0] = {32'h8000_0010, 32'h8000_0020};
    we_v[0]   = 2'b00;
    req_v[0]  = 2'b11;
    seen = 0; last_t = 0; t = 0;
    while (seen < 4 && t < 60) begin
      @(posedge clk);
      #1;
      t++;
      if (rdy_v[0] != 2'b00) begin
        chk("arb_onehot", 64'($countones(rdy_v[0])), 64'd1);
        order[seen] = rdy_v[0][1] ? 1 : 0;
        if (seen > 0) chk("arb_gap", 64'(t - last_t), 64'd3);
        last_t = t;
        seen++;
      end
    end
    @(negedge clk);
    req_v[0] = 2'b00;
    chk("arb_count", 64'(seen), 64'd4);
    for (int i = 0; i < 4; i++) chk("arb_order", 64'(order[i]), 64'(i % 2));
    chk("arb_rdata", rdata_v[0], 64'hDEAD_BEEF_11BB_33DD);

    // LATENCY=4 instance.
    xact(1, 0, 1'b1, 32'h8000_0040, 32'h0BAD_C0DE, 4'hF, rd, er, rv, cyc);
    chk("l4_wr_cyc", 64'(cyc), 64'd5);
    xact(1, 1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, rv, cyc);
    chk("l4_rd_cyc", 64'(cyc), 64'd5);
    chk("l4_rd_data", 64'(rd), 64'h0BAD_C0DE);
    xact(1, 0, 1'b1, 32'h8000_0044, 32'h5555_AAAA, 4'hF, rd, er, rv, cyc);
    chk("l4_other_hold", 64'(rdata_v[1][63:32]), 64'h0BAD_C0DE);

    // Reset mid-BUSY: grant master 0's write, reset one edge later (cnt=3).
    @(negedge clk);
    addr_v[1][31:0]  = 32'h8000_0040;
    wdata_v[1][31:0] = 32'hFFFF_FFFF;
    mask_v[1][3:0]   = 4'hF;
    we_v[1][0]       = 1'b1;
    req_v[1][0]      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_v[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("rstb_ready", 64'(rdy_v[1]), 64'd0);
    chk("rstb_err", 64'(err_v[1]), 64'd0);
    chk("rstb_rdata", rdata_v[1], 64'd0);
    @(negedge clk);
    rst_v[1]    = 1'b0;
    req_v[1][0] = 1'b0;
    bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rdy_v[1] != 2'b00) bad++;
    end
    chk("rstb_no_ready", 64'(bad), 64'd0);

    // Simultaneous request after reset: master 0 first, word unchanged.
    @(negedge clk);
    addr_v[1] = {32'h8000_0040, 32'h8000_0040};
    we_v[1]   = 2'b00;
    req_v[1]  = 2'b11;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (rdy_v[1] == 2'b00 && cyc < 40);
    chk("post_rst_grant", 64'(rdy_v[1]), 64'b01);
    chk("post_rst_cyc", 64'(cyc), 64'd5);
    chk("post_rst_word", 64'(rdata_v[1][31:0]), 64'h0BAD_C0DE);
    @(negedge clk);
    req_v[1] = 2'b00;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
